// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI slave register file.
//   spi_state_t    frame FSM state encoding
//   CMD_BITS       bits in the command byte
//   DATA_BITS      bits in the data byte
//   CNT_W          width of the per-byte bit counter
//   RW_READ/WRITE  encoding of the rw bit in the command byte
package spi_pkg;

  localparam int CMD_BITS  = 8;
  localparam int DATA_BITS = 8;
  localparam int CNT_W     = $clog2(CMD_BITS);

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer for one asynchronous input, with
// single-cycle rise/fall pulses from comparing the last stage to one more flop.
//   clk   in   system clock
//   rst   in   async active-high reset (all flops load RST_VAL)
//   d     in   asynchronous input
//   q     out  synchronized level
//   rise  out  one-clk pulse on synchronized 0->1
//   fall  out  one-clk pulse on synchronized 1->0
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev   <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev   <= sync_q[STAGES-1];
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile: SPI mode-0 slave giving a master access to four 8-bit
// registers. Frame is {rw, 5 x, addr[1:0]} then one data byte, MSB first.
//   clk        in   system clock
//   rst        in   async active-high reset
//   sclk       in   SPI clock (async)
//   mosi       in   SPI data in (async)
//   ss         in   SPI select, active-low (async)
//   miso       out  SPI data out; 0 unless returning read data
//   regs       out  register contents, register n at [8n+7:8n]
//   wr_strobe  out  one-clk pulse when a write commits
//   wr_addr    out  address of the committed write
//   frame_err  out  one-clk pulse when ss deasserts mid-frame
//
// state | meaning
// IDLE  | waiting for ss falling edge
// CMD   | shifting in the command byte
// DATA  | shifting data in (write) or out (read)
// HOLD  | frame complete, ignore sclk until ss deasserts
module spi_slave_regfile #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        ss,
  output logic        miso,
  output logic [31:0] regs,
  output logic        wr_strobe,
  output logic [1:0]  wr_addr,
  output logic        frame_err
);
  import spi_pkg::*;

  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
  // The ss synchronizer comes out of reset at 1 and needs this many cycles to
  // reflect the real pin; falls seen before then are not fresh selects.
  localparam int                  SETTLE_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SYNC_STAGES + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic ss_lvl, ss_rise, ss_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst(rst), .d(ss), .q(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, sclk_fall & 1'b0, mosi_rise, mosi_fall, ss_lvl};

  spi_state_t            state, state_next;
  logic [CNT_W-1:0]      cnt;
  logic [6:0]            shreg;
  logic [7:0]            shift_in;
  logic [7:0]            out_sh;
  logic                  rw_q;
  logic [1:0]            addr_q;
  logic [3:0][7:0]       reg_q;
  logic [SETTLE_W-1:0]   settle_cnt;
  logic                  armed;

  logic shift_en, cmd_done, wr_en, abort, miso_adv;

  assign shift_in = {shreg, mosi_s};
  assign armed    = (settle_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    cmd_done   = 1'b0;
    wr_en      = 1'b0;
    abort      = 1'b0;
    miso_adv   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (ss_fall && armed) state_next = ST_CMD;
      end
      ST_CMD: begin
        if (ss_rise) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
        end else if (sclk_rise) begin
          shift_en = 1'b1;
          if (cnt == CMD_LAST) begin
            cmd_done   = 1'b1;
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (ss_rise) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
        end else if (sclk_rise) begin
          shift_en = 1'b1;
          if (cnt == DATA_LAST) begin
            wr_en      = (rw_q == RW_WRITE);
            state_next = ST_HOLD;
          end
        end else if (sclk_fall && cnt != '0) begin
          // The first fall in DATA is the tail of the last command bit; bit 7
          // must stay on miso until the master samples it.
          miso_adv = (rw_q == RW_READ);
        end
      end
      ST_HOLD: begin
        if (ss_rise) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      shreg      <= '0;
      out_sh     <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      reg_q      <= RESET_VAL;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      frame_err  <= 1'b0;
      settle_cnt <= SETTLE_INIT;
    end else begin
      wr_strobe <= wr_en;
      frame_err <= abort;
      if (!armed) settle_cnt <= settle_cnt - 1'b1;

      if (cmd_done || state_next == ST_IDLE) cnt <= '0;
      else if (shift_en)                     cnt <= cnt + 1'b1;

      if (shift_en) shreg <= shift_in[6:0];

      if (cmd_done) begin
        rw_q   <= shift_in[7];
        addr_q <= shift_in[1:0];
        out_sh <= reg_q[shift_in[1:0]];
      end else if (miso_adv) begin
        out_sh <= {out_sh[6:0], 1'b0};
      end

      if (wr_en) begin
        reg_q[addr_q] <= shift_in;
        wr_addr       <= addr_q;
      end
    end
  end

  assign miso = (state == ST_DATA) && (rw_q == RW_READ) && out_sh[7];
  assign regs = reg_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// tb_spi_slave_regfile: randomized SPI master driving spi_slave_regfile,
// checked against a byte-array model of the four registers.
module tb_spi_slave_regfile;

  localparam int          SYNC  = 2;
  localparam logic [31:0] RVAL  = 32'hC35A_960F;
  localparam int          MINH  = SYNC + 2;
  localparam int          NOMH  = 6;

  logic        clk, rst, sclk, mosi, ss;
  logic        miso, wr_strobe, frame_err;
  logic [31:0] regs;
  logic [1:0]  wr_addr;

  spi_slave_regfile #(.SYNC_STAGES(SYNC), .RESET_VAL(RVAL)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .ss(ss),
    .miso(miso), .regs(regs), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int         n_strobe = 0;
  int         n_ferr = 0;
  int         n_miso_hi = 0;
  logic [1:0] last_wr_addr = 2'd0;
  logic       miso_zero = 1'b1;

  always @(negedge clk) begin
    if (wr_strobe) begin
      n_strobe     <= n_strobe + 1;
      last_wr_addr <= wr_addr;
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (miso_zero && miso) n_miso_hi <= n_miso_hi + 1;
  end

  logic [7:0] mdl [4];

  function automatic logic [31:0] mdl_packed();
    return {mdl[3], mdl[2], mdl[1], mdl[0]};
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 4; i++) mdl[i] = RVAL[8*i +: 8];
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Mode-0 master: nbits from tx (MSB first), capture miso just before each
  // rising sclk. Edges keep a fixed random offset from clk, never on posedge.
  task automatic spi_xfer(input logic [31:0] tx, input int nbits, input int half,
                          input int rst_bit, output logic [31:0] rx);
    int phase;
    phase = $urandom_range(1, 8);
    if (phase >= 5) phase++;
    rx = '0;
    @(negedge clk);
    #(phase);
    ss = 1'b0;
    #(half * 10);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = tx[i];
      if (i == rst_bit) begin
        rst = 1'b1;
        #20;
        rst = 1'b0;
      end
      #(half * 10);
      rx   = {rx[30:0], miso};
      sclk = 1'b1;
      #(half * 10);
      sclk = 1'b0;
    end
    #(half * 10);
    ss   = 1'b1;
    mosi = 1'b0;
    #((half + SYNC + 6) * 10);
  endtask

  task automatic frame_check(input string tag, input logic [7:0] cmd, input logic [7:0] dat,
                             input int nbits, input logic [15:0] tail, input int half);
    logic [31:0] tx, rx, dmask;
    logic [7:0]  exp_rd;
    logic [1:0]  a;
    logic        is_rd, complete;
    int          s0, e0, m0;
    tx       = {cmd, dat, tail} >> (32 - nbits);
    is_rd    = cmd[7];
    a        = cmd[1:0];
    complete = (nbits >= 16);
    exp_rd   = mdl[a];
    miso_zero = !is_rd;
    s0 = n_strobe; e0 = n_ferr; m0 = n_miso_hi;
    spi_xfer(tx, nbits, half, -1, rx);
    if (complete && !is_rd) mdl[a] = dat;
    check_eq({tag, "/regs"}, regs, mdl_packed());
    check_eq({tag, "/strobes"}, 32'(n_strobe - s0), (complete && !is_rd) ? 32'd1 : 32'd0);
    if (complete && !is_rd) check_eq({tag, "/wr_addr"}, 32'(last_wr_addr), 32'(a));
    check_eq({tag, "/frame_err"}, 32'(n_ferr - e0), complete ? 32'd0 : 32'd1);
    if (is_rd && complete) begin
      dmask = 32'hFF << (nbits - 16);
      check_eq({tag, "/rd_data"}, (rx >> (nbits - 16)) & 32'hFF, 32'(exp_rd));
      check_eq({tag, "/rd_quiet"}, rx & ~dmask, 32'd0);
    end else if (!is_rd) begin
      check_eq({tag, "/miso_zero"}, 32'(n_miso_hi - m0), 32'd0);
    end
    miso_zero = 1'b1;
  endtask

  initial begin
    #(3_000_000);
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rx;
    int          s0, e0;
    logic [7:0]  c, d;
    rst = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
    mdl_reset();
    repeat (4) @(negedge clk);
    check_eq("rst/regs", regs, RVAL);
    check_eq("rst/miso", 32'(miso), 32'd0);
    check_eq("rst/wr_strobe", 32'(wr_strobe), 32'd0);
    check_eq("rst/wr_addr", 32'(wr_addr), 32'd0);
    check_eq("rst/frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    repeat (SYNC + 4) @(negedge clk);

    frame_check("write2", 8'h02, 8'hA5, 16, 16'h0, NOMH);
    frame_check("read2", 8'h82, 8'h00, 16, 16'h0, NOMH);
    frame_check("abort", 8'h01, 8'hF0, 12, 16'h0, NOMH);
    frame_check("write1", 8'h01, 8'h3C, 16, 16'h0, NOMH);
    frame_check("overrun", 8'h03, 8'h7E, 24, 16'hFF00, NOMH);
    frame_check("read3_ovr", 8'h83, 8'h00, 24, 16'hFF00, NOMH);

    // reset during the data byte of a write to address 0
    miso_zero = 1'b1;
    s0 = n_strobe; e0 = n_ferr;
    spi_xfer({16'h0, 8'h00, 8'h5A}, 16, NOMH, 5, rx);
    mdl_reset();
    check_eq("rstmid/regs", regs, mdl_packed());
    check_eq("rstmid/strobes", 32'(n_strobe - s0), 32'd0);
    check_eq("rstmid/frame_err", 32'(n_ferr - e0), 32'd0);
    frame_check("post_rst_w0", 8'h00, 8'h69, 16, 16'h0, NOMH);
    frame_check("post_rst_r0", 8'h80, 8'h00, 16, 16'h0, NOMH);

    frame_check("min_w2", 8'h02, 8'hA5, 16, 16'h0, MINH);
    frame_check("min_r2", 8'h82, 8'h00, 16, 16'h0, MINH);
    frame_check("min_w2b", 8'h02, 8'h5A, 16, 16'h0, MINH);
    frame_check("min_r2b", 8'h82, 8'h00, 16, 16'h0, MINH);

    for (int k = 0; k < 20; k++) begin
      c = 8'($urandom);
      d = 8'($urandom);
      case ($urandom_range(0, 5))
        0:       frame_check("rnd_abort", c, d, $urandom_range(1, 15), 16'h0, MINH);
        1:       frame_check("rnd_ovr", c, d, 24, 16'($urandom), $urandom_range(MINH, MINH + 3));
        default: frame_check("rnd", c, d, 16, 16'h0, $urandom_range(MINH, MINH + 3));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
